mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data memory between the fetch stage and the data-access stage, which is driven by the decoder's memRead/memWrite. Data accesses take priority, with a starvation guard so fetch is still served. The block sequences each access through a registered request/acknowledge handshake with variable-latency memory. It sits between the pipeline stages and the memory model and drives a pipeline stall.

Parameters:
ADDR_W, 32, byte address width passed to memory
DATA_W, 32, data word width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (1..15)
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request (level, held until if_ack)
if_addr  in  ADDR_W  fetch address, stable while if_req
if_ack  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetched word, valid with if_ack and held until the next fetch completion
d_read  in  1  data load request (memRead)
d_write  in  1  data store request (memWrite)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  load data, valid with d_ack and held until the next data completion
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  one-cycle memory completion pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack
stall  out  1  combinational: (if_req & ~if_ack) | ((d_read|d_write) & ~d_ack)
err  out  1  sticky timeout flag (0 unless the optional feature is enabled)

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (asynchronous, immediate):
  - state=IDLE.
  - mem_req=0, mem_we=0; mem_addr, mem_wdata, if_rdata and d_rdata are 0.
  - if_ack=0, d_ack=0, err=0, starvation counter=0.
  - Reset mid-access abandons the access; no ack is issued.
  - A mem_ack arriving after reset is ignored.
- States: IDLE, D_BUSY, IF_BUSY.
- IDLE, candidate selection:
  - A requester whose ack is high this cycle is ignored, to avoid a double grant.
  - Data is the candidate if d_read|d_write.
  - Fetch is the candidate if if_req.
  - Both pending: grant data unless starve_cnt==STARVE_LIMIT, in which case grant fetch.
- Grant to data, on the registered edge:
  - mem_req=1, mem_addr=d_addr, mem_we=d_write, mem_wdata=d_wdata; go to D_BUSY.
  - If d_read and d_write are both high, the write wins.
  - starve_cnt increments (saturating) if if_req is high, else clears.
- Grant to fetch:
  - mem_req=1, mem_we=0, mem_addr=if_addr; go to IF_BUSY; starve_cnt=0.
- BUSY states:
  - mem_req and the address/data outputs are held stable until mem_ack.
  - On mem_ack: mem_req=0 next cycle; capture mem_rdata into the owner's rdata (loads and fetches only); pulse the owner's ack for exactly 1 cycle; return to IDLE.
  - Requester inputs are not re-sampled during BUSY.
- Latency: request seen in IDLE at cycle N → mem_req high at N+1 → mem_ack at N+1+L (L≥0 cycles after mem_req) → requester ack at N+2+L. Minimum 2 cycles. Back-to-back grants leave one IDLE cycle between them.
- mem_ack in IDLE is ignored.
- Requests withdrawn before grant are never issued. Withdrawal after grant is illegal; the access still completes and acks.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in each BUSY state. If it reaches TIMEOUT_CYCLES with no mem_ack, then: drop mem_req, pulse the owner's ack with rdata=32'hDEADBEEF, set err=1 (sticky until reset), return to IDLE.
- Not defined:
  - No counter is built; BUSY waits indefinitely; err is tied to 0.

Test Plan:
- Single load: d_read=1, d_addr=0x100, memory acks 3 cycles after mem_req with 0x12345678 → mem_we=0, mem_addr=0x100; d_ack pulses once, 5 cycles after the request; d_rdata=0x12345678.
- Store: d_write=1, d_addr=0x204, d_wdata=0xA5A5A5A5 → mem_we=1 with that address/data held until mem_ack; d_ack one pulse; d_rdata unchanged.
- Contention: if_req and d_read raised in the same cycle → data granted first; fetch granted after d_ack plus one IDLE cycle; both acks are single pulses.
- Starvation: d_read held continuously with if_req=1, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Async reset: assert rst_n=0 mid-D_BUSY, then send a stray mem_ack after release → mem_req falls immediately; no d_ack; state IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): fetch with no mem_ack → after 8 BUSY cycles if_ack pulses, if_rdata=0xDEADBEEF, err=1 and stays set.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and data access: data first, with a fetch starvation guard.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort accesses the memory never acknowledges.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  // Handshake: a requester holds its level request with stable operands until its one-cycle ack;
  // mem_req is likewise held with stable operands until the one-cycle mem_ack.

  typedef enum logic [1:0] {IDLE, D_BUSY, IF_BUSY} state_e;

  localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [DATA_W-1:0] TMO_DATA   = DATA_W'(32'hDEADBEEF);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]        starve_q, starve_d;
  logic              d_cand, f_cand, starve_hit, timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // The counter restarts in IDLE, so it measures cycles spent in the current access only.
  assign timeout = (state_q != IDLE) && !mem_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_d   = (state_q == IDLE) ? '0 : tmo_q + TMO_W'(1);
  assign err_d   = err_q | timeout;
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // A requester being acked this cycle still shows its old request; ignore it to avoid a double grant.
  assign d_cand     = (d_read | d_write) & ~d_ack_q;
  assign f_cand     = if_req & ~if_ack_q;
  assign starve_hit = (starve_q == STARVE_MAX);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;
    case (state_q)
      IDLE: begin
        if (d_cand && (!f_cand || !starve_hit)) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          starve_d    = if_req ? (starve_hit ? starve_q : starve_q + 4'd1) : 4'd0;
        end else if (f_cand) begin
          state_d    = IF_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = 4'd0;
        end
      end
      D_BUSY, IF_BUSY: begin
        if (mem_ack || timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == D_BUSY) begin
            d_ack_d = 1'b1;
            if (timeout)        d_rdata_d = TMO_DATA;
            else if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = timeout ? TMO_DATA : mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      starve_q    <= starve_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (if_req & ~if_ack_q) | ((d_read | d_write) & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Define MEM_ARB_TIMEOUT_EN for both files to also exercise the watchdog.
module tb_mem_port_arbiter;
  localparam int LIM = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 64;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_ack, d_ack, mem_req, mem_we, stall, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the memory, what it was asked, and what each requester last received.
  int          m_owner;  // 0 none, 1 data, 2 fetch
  int          m_starve, m_busy;
  bit          m_req, m_we, m_if_ack, m_d_ack, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

  // Memory responder and observation state.
  int fixed_lat = -1;
  bit fixed_rd_en = 1'b0, force_ack = 1'b0, mem_done = 1'b0, prev_req = 1'b0;
  logic [31:0] fixed_rd = '0;
  int lat = 0;
  int mode = 0;  // 0 directed (drop on ack), 1 starvation pattern, 2 random
  int cyc = 0;
  int d_ack_cnt, if_ack_cnt, d_ack_cyc, if_ack_cyc, f_grant_cyc;
  logic [31:0] g_addr, g_wdata;
  bit g_we;
  int grant_q[$];

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_busy = 0;
    m_req = 0; m_we = 0; m_if_ack = 0; m_d_ack = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
  endtask

  task automatic clear_counts();
    d_ack_cnt = 0; if_ack_cnt = 0; d_ack_cyc = -1; if_ack_cyc = -1; f_grant_cyc = -1;
    grant_q.delete();
  endtask

  task automatic model_step();
    bit dc, fc, timed;
    logic [31:0] rd;
    if (m_owner == 0) begin
      dc = (d_read || d_write) && !m_d_ack;
      fc = if_req && !m_if_ack;
      m_if_ack = 0; m_d_ack = 0;
      if (dc && !(fc && m_starve == LIM)) begin
        m_owner = 1; m_req = 1; m_we = d_write; m_addr = d_addr; m_wdata = d_wdata; m_busy = 0;
        m_starve = if_req ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
      end else if (fc) begin
        m_owner = 2; m_req = 1; m_we = 0; m_addr = if_addr; m_busy = 0; m_starve = 0;
      end
    end else begin
      m_if_ack = 0; m_d_ack = 0;
      timed = TMO_EN && !mem_ack && (m_busy == TMO - 1);
      if (mem_ack || timed) begin
        rd = timed ? 32'hDEADBEEF : mem_rdata;
        if (m_owner == 1) begin
          m_d_ack = 1;
          if (timed || !m_we) m_d_rdata = rd;
        end else begin
          m_if_ack = 1;
          m_if_rdata = rd;
        end
        m_err = m_err | timed;
        m_req = 0; m_we = 0; m_owner = 0;
      end else begin
        m_busy++;
      end
    end
  endtask

  // Post-edge sampling of every registered output against the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("mem_req", 32'(mem_req), 32'(m_req));
    check_eq("mem_we", 32'(mem_we), 32'(m_we));
    check_eq("mem_addr", mem_addr, m_addr);
    check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("if_ack", 32'(if_ack), 32'(m_if_ack));
    check_eq("d_ack", 32'(d_ack), 32'(m_d_ack));
    check_eq("if_rdata", if_rdata, m_if_rdata);
    check_eq("d_rdata", d_rdata, m_d_rdata);
    check_eq("err", 32'(err), 32'(m_err));
    if (d_ack) begin d_ack_cnt++; if (d_ack_cyc < 0) d_ack_cyc = cyc; end
    if (if_ack) begin if_ack_cnt++; if (if_ack_cyc < 0) if_ack_cyc = cyc; end
    if (mem_req && !prev_req) begin
      grant_q.push_back((mem_addr[31:28] == 4'hF) ? 2 : 1);
      g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
      if (mem_addr[31:28] == 4'hF && f_grant_cyc < 0) f_grant_cyc = cyc;
    end
    prev_req = mem_req;
  endtask

  // Memory responder, combinational stall check, then advance the model across the coming edge.
  task automatic eval();
    bit exp_stall;
    mem_ack = 0;
    mem_rdata = $urandom;
    if (force_ack) begin
      mem_ack = 1;
    end else if (mem_req && !mem_done) begin
      if (lat == 0) begin
        mem_ack = 1; mem_done = 1;
        if (fixed_rd_en) mem_rdata = fixed_rd;
      end else begin
        lat--;
      end
    end else if (!mem_req) begin
      mem_done = 0;
      lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
    #1;
    exp_stall = (if_req && !m_if_ack) || ((d_read || d_write) && !m_d_ack);
    check_eq("stall", 32'(stall), 32'(exp_stall));
    model_step();
  endtask

  task automatic drive();
    if (mode == 1) begin
      if (if_req && if_ack) if_req = 0;
      else if (d_ack && m_owner != 2) if_req = 0;
      else begin if_req = 1; if_addr = 32'hF000_0000 | 32'(cyc << 2); end
      d_read = 1; d_write = 0;
      if (d_ack) d_addr = 32'h0000_1000 + 32'(cyc << 2);
    end else if (mode == 2) begin
      if (if_req && if_ack) if_req = 0;
      else if (if_req && m_owner != 2 && $urandom_range(0, 15) == 0) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 32'hF000_0000 | (32'($urandom_range(0, 32'hFFFF)) & 32'hFFFC);
      end
      if ((d_read || d_write) && d_ack) begin d_read = 0; d_write = 0; end
      else if ((d_read || d_write) && m_owner != 1 && $urandom_range(0, 15) == 0) begin
        d_read = 0; d_write = 0;
      end else if (!(d_read || d_write) && $urandom_range(0, 1) == 0) begin
        int op;
        op = int'($urandom_range(0, 2));
        d_read = (op != 1); d_write = (op != 0);
        d_addr = 32'($urandom_range(0, 32'hFFFF)) & 32'hFFFC;
        d_wdata = $urandom;
      end
    end else begin
      if (if_req && if_ack) if_req = 0;
      if ((d_read || d_write) && d_ack) begin d_read = 0; d_write = 0; end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      drive();
      eval();
    end
  endtask

  task automatic do_reset();
    if_req = 0; d_read = 0; d_write = 0; mem_ack = 0;
    rst_n = 0;
    #1;
    check_eq("rst mem_req", 32'(mem_req), 32'd0);
    check_eq("rst mem_we", 32'(mem_we), 32'd0);
    check_eq("rst mem_addr", mem_addr, 32'd0);
    check_eq("rst mem_wdata", mem_wdata, 32'd0);
    check_eq("rst if_ack", 32'(if_ack), 32'd0);
    check_eq("rst d_ack", 32'(d_ack), 32'd0);
    check_eq("rst if_rdata", if_rdata, 32'd0);
    check_eq("rst d_rdata", d_rdata, 32'd0);
    check_eq("rst err", 32'(err), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    mem_done = 0; prev_req = 0; lat = 0;
  endtask

  int c0;

  initial begin
    model_reset();
    clear_counts();
    do_reset();
    tick(2);

    // Single load, memory answers 3 cycles after mem_req.
    clear_counts();
    fixed_lat = 3; fixed_rd_en = 1; fixed_rd = 32'h1234_5678; mode = 0;
    cycle(); d_read = 1; d_addr = 32'h100; eval(); c0 = cyc;
    tick(10);
    check_eq("load addr", g_addr, 32'h100);
    check_eq("load we", 32'(g_we), 32'd0);
    check_eq("load ack count", 32'(d_ack_cnt), 32'd1);
    check_eq("load latency", 32'(d_ack_cyc - c0), 32'd5);
    check_eq("load rdata", d_rdata, 32'h1234_5678);

    // Store: read data must not change.
    clear_counts();
    fixed_lat = 2;
    cycle(); d_write = 1; d_addr = 32'h204; d_wdata = 32'hA5A5_A5A5; eval();
    tick(10);
    check_eq("store we", 32'(g_we), 32'd1);
    check_eq("store addr", g_addr, 32'h204);
    check_eq("store wdata", g_wdata, 32'hA5A5_A5A5);
    check_eq("store ack count", 32'(d_ack_cnt), 32'd1);
    check_eq("store rdata kept", d_rdata, 32'h1234_5678);

    // Contention: both raised together, data wins, fetch follows.
    clear_counts();
    fixed_lat = 1; fixed_rd_en = 0;
    cycle(); d_read = 1; d_addr = 32'h300; if_req = 1; if_addr = 32'hF000_0040; eval();
    tick(12);
    check_eq("contend grants", 32'(grant_q.size()), 32'd2);
    if (grant_q.size() >= 2) begin
      check_eq("contend first", 32'(grant_q[0]), 32'd1);
      check_eq("contend second", 32'(grant_q[1]), 32'd2);
    end
    check_eq("contend fetch gap", 32'(f_grant_cyc - d_ack_cyc), 32'd1);
    check_eq("contend d_ack count", 32'(d_ack_cnt), 32'd1);
    check_eq("contend if_ack count", 32'(if_ack_cnt), 32'd1);

    // Starvation guard: LIM data grants, then one fetch, then data again.
    clear_counts();
    fixed_lat = 0; mode = 1;
    d_addr = 32'h1000;
    tick(40);
    mode = 0;
    tick(15);
    check_eq("starve grants", 32'(grant_q.size() >= 6), 32'd1);
    if (grant_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) check_eq("starve order", 32'(grant_q[i]), (i == LIM) ? 32'd2 : 32'd1);
    end

    // Asynchronous reset during a data access, then a stray mem_ack.
    fixed_lat = 1000;
    cycle(); d_read = 1; d_addr = 32'h400; eval();
    tick(3);
    do_reset();
    clear_counts();
    cycle(); force_ack = 1; eval(); force_ack = 0;
    tick(4);
    check_eq("reset no d_ack", 32'(d_ack_cnt), 32'd0);
    check_eq("reset no grant", 32'(grant_q.size()), 32'd0);

    // Random traffic with random memory latency.
    fixed_lat = -1; mode = 2;
    tick(3000);
    mode = 0;
    tick(30);

`ifdef MEM_ARB_TIMEOUT_EN
    clear_counts();
    fixed_lat = 1000;
    cycle(); if_req = 1; if_addr = 32'hF000_0100; eval(); c0 = cyc;
    tick(14);
    check_eq("tmo if_ack count", 32'(if_ack_cnt), 32'd1);
    check_eq("tmo latency", 32'(if_ack_cyc - c0), 32'd9);
    check_eq("tmo if_rdata", if_rdata, 32'hDEADBEEF);
    check_eq("tmo err", 32'(err), 32'd1);
    fixed_lat = 1;
    tick(10);
    check_eq("tmo err sticky", 32'(err), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
